// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core: reset PC, instruction
// memory sizing, opcode/funct encodings and the fetch-unit state type.
package cpu_pkg;

  localparam int          IM_AW    = 10;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  // Opcode / funct encodings seen by the fetch unit's control-flow inputs
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] FN_JR      = 6'h08;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Branch displacement: sign-extended 16-bit word offset scaled to bytes
  function automatic logic signed [31:0] br_offset(input logic [15:0] imm);
    logic signed [31:0] ext;
    ext = {{14{imm[15]}}, imm, 2'b00};
    return ext;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Load port and controller-facing fetch signals of the instruction fetch unit.
interface instr_fetch_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        nPC_sel;
  logic        br_taken;
  logic        j;
  logic        jal;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        pc_fault;

  // Loader / controller side
  modport master (
    output load_valid, load_data, load_done,
    output nPC_sel, br_taken, j, jal, jr, jr_target,
    input  load_ready, instr, pc, pc_plus4, fetch_valid, pc_fault
  );

  // Fetch unit side
  modport slave (
    input  load_valid, load_data, load_done,
    input  nPC_sel, br_taken, j, jal, jr, jr_target,
    output load_ready, instr, pc, pc_plus4, fetch_valid, pc_fault
  );
endinterface

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: synchronous write, asynchronous read.
// Contents are deliberately not reset so an image survives a core reset.
module instr_mem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  // Program image write from the load port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: loads a program image, then holds the PC, presents
// the current instruction and computes the next PC from control-flow flags.
module instr_fetch #(
  parameter int          IM_AW    = cpu_pkg::IM_AW,
  parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.slave  bus
);
  import cpu_pkg::*;

  localparam logic [IM_AW-1:0] WPTR_LAST = '1;

  fetch_state_e     state_q;
  logic [IM_AW-1:0] wptr_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic             fault_q;
  logic             load_ready_q;
  logic             fetch_valid_q;

  logic [31:0]      pc_off;
  logic [31:0]      pc_plus4;
  logic [31:0]      im_rdata;
  logic [31:0]      instr;
  logic             pc_ok;
  logic             im_we;

  // Offset into the IM window; modulo arithmetic makes a PC below the base
  // land far above the window, so one range test covers both sides.
  assign pc_off   = pc_q - PC_RESET;
  assign pc_ok    = (pc_off[31:IM_AW+2] == '0) && (pc_off[1:0] == 2'b00);
  assign pc_plus4 = pc_q + 32'd4;
  assign im_we    = (state_q == ST_LOAD) && bus.load_valid;

  instr_mem #(.AW(IM_AW)) u_instr_mem (
    .clk     (clk),
    .we_i    (im_we),
    .waddr_i (wptr_q),
    .wdata_i (bus.load_data),
    .raddr_i (pc_off[IM_AW+1:2]),
    .rdata_o (im_rdata)
  );

  // Faulted or not-yet-running fetches present a nop
  assign instr = (fetch_valid_q && pc_ok) ? im_rdata : 32'h0;

  // Next PC: jr over j/jal over taken branch over sequential
  always_comb begin
    pc_d = pc_plus4;
    if (bus.jr) begin
      pc_d = bus.jr_target;
    end else if (bus.j || bus.jal) begin
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (bus.nPC_sel && bus.br_taken) begin
      pc_d = pc_plus4 + unsigned'(br_offset(instr[15:0]));
    end
  end

  // LOAD/RUN sequencing, write pointer, PC register and sticky fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      wptr_q        <= '0;
      pc_q          <= PC_RESET;
      fault_q       <= 1'b0;
      load_ready_q  <= 1'b1;
      fetch_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.load_valid) wptr_q <= wptr_q + 1'b1;
          if (bus.load_done || (bus.load_valid && wptr_q == WPTR_LAST)) begin
            state_q       <= ST_RUN;
            wptr_q        <= '0;
            load_ready_q  <= 1'b0;
            fetch_valid_q <= 1'b1;
          end
        end
        ST_RUN: begin
          pc_q <= pc_d;
          if (!pc_ok) fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instr       = instr;
  // Fault is visible in the very cycle the bad PC is presented, then held
  assign bus.pc_fault    = fault_q | (fetch_valid_q & ~pc_ok);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of expected fetch states.
module tb_instr_fetch;

  logic clk;
  logic rst_n;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fv;
    logic        lr;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic fv, input logic lr, input logic flt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.instr = instr; e.fv = fv; e.lr = lr; e.flt = flt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".pc"},          bus.pc,                  e.pc);
    cmp({e.tag, ".pc_plus4"},    bus.pc_plus4,            e.pc + 32'd4);
    cmp({e.tag, ".instr"},       bus.instr,               e.instr);
    cmp({e.tag, ".fetch_valid"}, {31'b0, bus.fetch_valid}, {31'b0, e.fv});
    cmp({e.tag, ".load_ready"},  {31'b0, bus.load_ready},  {31'b0, e.lr});
    cmp({e.tag, ".pc_fault"},    {31'b0, bus.pc_fault},    {31'b0, e.flt});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One RUN cycle: drive controller flags, predict the next fetch, clock, compare
  task automatic run(input string tag, input logic n, input logic b, input logic jj,
                     input logic jl, input logic r, input logic [31:0] tgt,
                     input logic [31:0] epc, input logic [31:0] einstr, input logic eflt);
    bus.nPC_sel = n; bus.br_taken = b; bus.j = jj; bus.jal = jl; bus.jr = r;
    bus.jr_target = tgt;
    push_exp(tag, epc, einstr, 1'b1, 1'b0, eflt);
    cyc();
    check_out();
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    push_exp(tag, 32'h3000, 32'h0, 1'b0, 1'b1, 1'b0);
    check_out();
    #1 rst_n = 1'b1;
    cyc();
  endtask

  logic [31:0] prog [17];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_done = 1'b0;
    bus.nPC_sel = 1'b0; bus.br_taken = 1'b0; bus.j = 1'b0; bus.jal = 1'b0;
    bus.jr = 1'b0; bus.jr_target = '0;

    foreach (prog[i]) prog[i] = 32'h0;
    prog[0] = 32'h3408_0005;
    prog[2] = 32'h1000_FFFE;
    prog[4] = 32'h0800_0C10;

    #12;
    push_exp("reset", 32'h3000, 32'h0, 1'b0, 1'b1, 1'b0);
    check_out();
    rst_n = 1'b1;

    // Program load; the last word carries load_done and must still be written
    for (int i = 0; i < 17; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = prog[i];
      bus.load_done  = (i == 16);
      if (i == 16) push_exp("load_last", 32'h3000, 32'h3408_0005, 1'b1, 1'b0, 1'b0);
      else         push_exp("load", 32'h3000, 32'h0, 1'b0, 1'b1, 1'b0);
      cyc();
      check_out();
    end
    bus.load_valid = 1'b0; bus.load_done = 1'b0;

    run("seq0",     0, 0, 0, 0, 0, 32'h0,    32'h3004, 32'h0,         0);
    run("seq1",     0, 0, 0, 0, 0, 32'h0,    32'h3008, 32'h1000_FFFE, 0);
    run("br_taken", 1, 1, 0, 0, 0, 32'h0,    32'h3004, 32'h0,         0);
    run("seq2",     0, 0, 0, 0, 0, 32'h0,    32'h3008, 32'h1000_FFFE, 0);
    run("br_not",   1, 0, 0, 0, 0, 32'h0,    32'h300C, 32'h0,         0);
    run("seq3",     0, 0, 0, 0, 0, 32'h0,    32'h3010, 32'h0800_0C10, 0);
    run("j",        0, 0, 1, 0, 0, 32'h0,    32'h3040, 32'h0,         0);
    run("jr_over_j",0, 0, 1, 0, 1, 32'h3010, 32'h3010, 32'h0800_0C10, 0);
    run("jal",      0, 0, 0, 1, 0, 32'h0,    32'h3040, 32'h0,         0);
    run("jr_j_prio",0, 0, 1, 0, 1, 32'h3020, 32'h3020, 32'h0,         0);
    run("jr_misal", 0, 0, 0, 0, 1, 32'h3022, 32'h3022, 32'h0,         1);
    run("flt_seq",  0, 0, 0, 0, 0, 32'h0,    32'h3026, 32'h0,         1);
    run("flt_stky", 0, 0, 0, 0, 1, 32'h3040, 32'h3040, 32'h0,         1);
    bus.jr = 1'b0;

    // Reset mid-RUN, then a zero-length load reruns the retained image
    pulse_reset("rst_mid");
    bus.load_done = 1'b1;
    push_exp("reload", 32'h3000, 32'h3408_0005, 1'b1, 1'b0, 1'b0);
    cyc();
    check_out();
    bus.load_done = 1'b0;

    // Fill every IM word without load_done; RUN follows the last write
    pulse_reset("rst_fill");
    for (int i = 0; i < 1024; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 32'hC0DE_0000 | i;
      if (i == 1023) push_exp("fill_last", 32'h3000, 32'hC0DE_0000, 1'b1, 1'b0, 1'b0);
      else           push_exp("fill", 32'h3000, 32'h0, 1'b0, 1'b1, 1'b0);
      cyc();
      check_out();
    end
    // Load port is ignored in RUN; IM[0] must not be overwritten
    bus.load_data = 32'hDEAD_BEEF;
    bus.load_done = 1'b1;
    run("run_ign",  0, 0, 0, 0, 0, 32'h0,    32'h3004, 32'hC0DE_0001, 0);
    bus.load_valid = 1'b0; bus.load_done = 1'b0;
    run("im0_keep", 0, 0, 0, 0, 1, 32'h3000, 32'h3000, 32'hC0DE_0000, 0);
    run("im_top",   0, 0, 0, 0, 1, 32'h3FFC, 32'h3FFC, 32'hC0DE_03FF, 0);
    run("im_past",  0, 0, 0, 0, 0, 32'h0,    32'h4000, 32'h0,         1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
